// File: rtl/eth_tx_gmii_framer_if.sv
// rtl/eth_tx_gmii_framer_if.sv - byte stream feeding the GMII transmit framer
//
// Signals:
//   tdata  [7:0]  payload byte
//   tvalid        payload byte valid
//   tready        byte accepted when tvalid & tready
//   tlast         last payload byte of the frame
//   tuser         bad-frame mark, meaningful on the tlast beat
// Modports: master (source side), slave (framer side).

interface eth_tx_gmii_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/eth_tx_gmii_framer.sv
// rtl/eth_tx_gmii_framer.sv - byte stream to GMII framer with preamble, pad, FCS and IFG
//
// Ports:
//   tx_clk           transmit clock, all logic on the rising edge
//   tx_rst           asynchronous active-high reset
//   s_axis           payload stream (slave side of eth_tx_gmii_framer_if)
//   gmii_txd [7:0]   transmit byte (registered)
//   gmii_tx_en       transmit enable (registered)
//   gmii_tx_er       transmit error (registered)
//   cfg_ifg  [7:0]   inter-frame gap in cycles, sampled when the gap starts
//   cfg_tx_enable    gates the start of new frames only
//   start_packet     one-cycle pulse alongside the first preamble byte
//   error_underflow  one-cycle pulse when the source runs dry mid-frame
//
// Parameters:
//   ENABLE_PADDING    1: pad short frames with 0x00 up to MIN_FRAME_LENGTH
//   MIN_FRAME_LENGTH  minimum frame length in bytes, FCS included

module eth_tx_gmii_framer #(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic                        tx_clk,
  input  logic                        tx_rst,
  eth_tx_gmii_framer_if.slave         s_axis,
  output logic [7:0]                  gmii_txd,
  output logic                        gmii_tx_en,
  output logic                        gmii_tx_er,
  input  logic [7:0]                  cfg_ifg,
  input  logic                        cfg_tx_enable,
  output logic                        start_packet,
  output logic                        error_underflow
);

  // Minimum payload+pad length; the FCS supplies the remaining 4 bytes.
  localparam int          MIN_PAY_I = (MIN_FRAME_LENGTH > 4) ? (MIN_FRAME_LENGTH - 4) : 0;
  localparam logic [15:0] MIN_PAY   = 16'(MIN_PAY_I);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    PAYLOAD  = 3'd2,
    PAD      = 3'd3,
    FCS      = 3'd4,
    IFG      = 3'd5,
    DRAIN    = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // sub_cnt indexes the 8 preamble bytes and the 4 FCS bytes.
  logic [2:0]  sub_cnt;
  logic [15:0] byte_cnt;
  logic [15:0] byte_cnt_inc;
  logic [31:0] crc;
  logic [31:0] crc_inv;
  logic [7:0]  ifg_cnt;
  logic        bad_frame;

  // Next values for the registered outputs and datapath strobes.
  logic [7:0]  txd_nxt;
  logic        tx_en_nxt;
  logic        tx_er_nxt;
  logic        start_nxt;
  logic        underflow_nxt;
  logic        crc_en;
  logic [7:0]  crc_data;
  logic        cnt_en;
  logic        ifg_load;
  logic        last_beat;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // The counter saturates so oversize frames never wrap back under the pad threshold.
  assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : (byte_cnt + 16'd1);

  assign crc_inv = ~crc;

  always_comb begin
    fcs_byte = crc_inv[7:0];
    case (sub_cnt[1:0])
      2'd0:    fcs_byte = crc_inv[7:0];
      2'd1:    fcs_byte = crc_inv[15:8];
      2'd2:    fcs_byte = crc_inv[23:16];
      default: fcs_byte = crc_inv[31:24];
    endcase
  end

  // Ready is decoded from the state register only, so the source never sees
  // a combinational path back from its own tvalid.
  assign s_axis.tready = (state == PAYLOAD) || (state == DRAIN);

  assign last_beat = s_axis.tvalid && s_axis.tlast;

  // FSM state register.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next registered-output values.
  always_comb begin
    state_nxt     = state;
    txd_nxt       = 8'h00;
    tx_en_nxt     = 1'b0;
    tx_er_nxt     = 1'b0;
    start_nxt     = 1'b0;
    underflow_nxt = 1'b0;
    crc_en        = 1'b0;
    crc_data      = 8'h00;
    cnt_en        = 1'b0;
    ifg_load      = 1'b0;

    case (state)
      IDLE: begin
        // Only the start of a frame is gated; no byte is consumed here.
        if (s_axis.tvalid && cfg_tx_enable) begin
          state_nxt = PREAMBLE;
        end
      end

      PREAMBLE: begin
        tx_en_nxt = 1'b1;
        txd_nxt   = (sub_cnt == 3'd7) ? 8'hD5 : 8'h55;
        start_nxt = (sub_cnt == 3'd0);
        if (sub_cnt == 3'd7) begin
          state_nxt = PAYLOAD;
        end
      end

      PAYLOAD: begin
        tx_en_nxt = 1'b1;
        if (s_axis.tvalid) begin
          txd_nxt  = s_axis.tdata;
          crc_en   = 1'b1;
          crc_data = s_axis.tdata;
          cnt_en   = 1'b1;
          if (s_axis.tlast) begin
            if ((ENABLE_PADDING != 0) && (byte_cnt_inc < MIN_PAY)) begin
              state_nxt = PAD;
            end else begin
              state_nxt = FCS;
            end
          end
        end else begin
          // Source ran dry before tlast: poison the frame on the wire and
          // swallow the rest of it upstream.
          tx_er_nxt     = 1'b1;
          underflow_nxt = 1'b1;
          state_nxt     = DRAIN;
        end
      end

      PAD: begin
        tx_en_nxt = 1'b1;
        crc_en    = 1'b1;
        cnt_en    = 1'b1;
        if (byte_cnt_inc >= MIN_PAY) begin
          state_nxt = FCS;
        end
      end

      FCS: begin
        tx_en_nxt = 1'b1;
        txd_nxt   = fcs_byte;
        tx_er_nxt = bad_frame;
        if (sub_cnt == 3'd3) begin
          ifg_load  = 1'b1;
          state_nxt = IFG;
        end
      end

      IFG: begin
        if (ifg_cnt <= 8'd1) begin
          state_nxt = IDLE;
        end
      end

      DRAIN: begin
        if (last_beat) begin
          ifg_load  = 1'b1;
          state_nxt = IFG;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      gmii_txd        <= 8'h00;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
      sub_cnt         <= 3'd0;
      byte_cnt        <= 16'd0;
      crc             <= CRC_INIT;
      ifg_cnt         <= 8'd0;
      bad_frame       <= 1'b0;
    end else begin
      gmii_txd        <= txd_nxt;
      gmii_tx_en      <= tx_en_nxt;
      gmii_tx_er      <= tx_er_nxt;
      start_packet    <= start_nxt;
      error_underflow <= underflow_nxt;

      if (state_nxt != state) begin
        sub_cnt <= 3'd0;
      end else if ((state == PREAMBLE) || (state == FCS)) begin
        sub_cnt <= sub_cnt + 3'd1;
      end

      // Every frame passes through IDLE, so per-frame state is rearmed there.
      if (state == IDLE) begin
        byte_cnt  <= 16'd0;
        crc       <= CRC_INIT;
        bad_frame <= 1'b0;
      end else begin
        if (crc_en) begin
          crc <= crc32_byte(crc, crc_data);
        end
        if (cnt_en) begin
          byte_cnt <= byte_cnt_inc;
        end
        if ((state == PAYLOAD) && last_beat) begin
          bad_frame <= s_axis.tuser;
        end
      end

      // A zero gap setting still leaves one idle cycle in IFG.
      if (ifg_load) begin
        ifg_cnt <= (cfg_ifg == 8'd0) ? 8'd1 : cfg_ifg;
      end else if ((state == IFG) && (ifg_cnt != 8'd0)) begin
        ifg_cnt <= ifg_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_gmii_framer.sv
// tb/tb_eth_tx_gmii_framer.sv - self-checking bench for eth_tx_gmii_framer

module tb_eth_tx_gmii_framer;

  localparam int MIN_PAY    = 60;
  localparam int ACC_LIMIT  = 400;
  localparam int N_RND      = 16;

  logic       tx_clk = 1'b0;
  logic       tx_rst;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic [7:0] cfg_ifg;
  logic       cfg_tx_enable;
  logic       start_packet;
  logic       error_underflow;

  eth_tx_gmii_framer_if bus ();

  eth_tx_gmii_framer #(
    .ENABLE_PADDING   (1),
    .MIN_FRAME_LENGTH (64)
  ) dut (
    .tx_clk          (tx_clk),
    .tx_rst          (tx_rst),
    .s_axis          (bus),
    .gmii_txd        (gmii_txd),
    .gmii_tx_en      (gmii_tx_en),
    .gmii_tx_er      (gmii_tx_er),
    .cfg_ifg         (cfg_ifg),
    .cfg_tx_enable   (cfg_tx_enable),
    .start_packet    (start_packet),
    .error_underflow (error_underflow)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    logic       en;
    logic       er;
    logic       sp;
    logic       uf;
    logic [7:0] d;
  } samp_t;

  typedef struct {
    int         len;
    bit         bad;
    logic [7:0] base;
    int         exp_en;
    int         exp_er;
  } vec_t;

  samp_t       log_q[$];
  int          run_start[$];
  int          run_len[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] crc_tbl[256];
  int          n_checks = 0;
  int          n_errors = 0;

  always @(negedge tx_clk) begin
    if (!tx_rst) begin
      log_q.push_back('{en: gmii_tx_en, er: gmii_tx_er, sp: start_packet,
                        uf: error_underflow, d: gmii_txd});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got time %0t required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    return crc_tbl[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  // Expected wire image of a good frame built from the payload in pay_q.
  task automatic build_model();
    logic [7:0]  body[$];
    logic [31:0] c;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    body = pay_q;
    while (body.size() < MIN_PAY) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      c = crc_step(c, body[i]);
      exp_q.push_back(body[i]);
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  // Present pay_q[first..last_excl-1]; each byte waits for a cycle with tready.
  task automatic drive_range(input int first, input int last_excl, input bit bad, output bit ok);
    bit rdy;
    int n;
    ok = 1'b1;
    for (int i = first; i < last_excl; i++) begin
      bus.tvalid = 1'b1;
      bus.tdata  = pay_q[i];
      bus.tlast  = (i == pay_q.size() - 1);
      bus.tuser  = bad && (i == pay_q.size() - 1);
      n = 0;
      do begin
        @(negedge tx_clk);
        rdy = bus.tready;
        @(posedge tx_clk);
        #1;
        n++;
      end while (!rdy && n < ACC_LIMIT);
      if (!rdy) begin
        $display("FAIL accept_timeout: got no tready after %0d cycles required accept of byte %0d", n, i);
        n_errors++;
        ok = 1'b0;
        break;
      end
    end
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    bus.tuser  = 1'b0;
  endtask

  task automatic drive_frame(input bit bad, output bit ok);
    drive_range(0, pay_q.size(), bad, ok);
  endtask

  task automatic find_runs();
    run_start.delete();
    run_len.delete();
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].en && (i == 0 || !log_q[i-1].en)) begin
        int j;
        j = i;
        while (j < log_q.size() && log_q[j].en) j++;
        run_start.push_back(i);
        run_len.push_back(j - i);
      end
    end
  endtask

  task automatic check_frame(input int r, input bit bad, input string nm);
    int          s, n, m, wrong, er_wrong, sp_cnt;
    logic [31:0] c;
    s = run_start[r];
    n = run_len[r];
    check({nm, "_len"}, n, exp_q.size());
    m = (n < exp_q.size()) ? n : exp_q.size();
    wrong = 0;
    for (int i = 0; i < m; i++) if (log_q[s+i].d !== exp_q[i]) wrong++;
    check({nm, "_bytes_wrong"}, wrong, 0);
    er_wrong = 0;
    sp_cnt   = 0;
    for (int i = 0; i < n; i++) begin
      if (log_q[s+i].er !== (bad && (i >= n - 4))) er_wrong++;
      if (log_q[s+i].sp) sp_cnt++;
    end
    check({nm, "_er_wrong"}, er_wrong, 0);
    check({nm, "_start_first"}, log_q[s].sp, 1);
    check({nm, "_start_count"}, sp_cnt, 1);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < n; i++) c = crc_step(c, log_q[s+i].d);
    check({nm, "_residue"}, c, 32'hDEBB_20E3);
  endtask

  function automatic int count_er(input int r);
    int k = 0;
    for (int i = 0; i < run_len[r]; i++) if (log_q[run_start[r]+i].er) k++;
    return k;
  endfunction

  function automatic int count_uf();
    int k = 0;
    foreach (log_q[i]) if (log_q[i].uf) k++;
    return k;
  endfunction

  vec_t        vecs[6];
  int          len_a[N_RND];
  bit          bad_a[N_RND];
  int          ifg_a[N_RND];
  int          off_a[N_RND];
  logic [7:0]  rnd_pay[$];
  bit          ok;

  initial begin
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tbl[n] = c;
    end

    tx_rst        = 1'b1;
    cfg_tx_enable = 1'b1;
    cfg_ifg       = 8'd12;
    bus.tvalid    = 1'b0;
    bus.tdata     = 8'h00;
    bus.tlast     = 1'b0;
    bus.tuser     = 1'b0;

    // Reset state.
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    check("rst_txd", gmii_txd, 8'h00);
    check("rst_tx_en", gmii_tx_en, 0);
    check("rst_tx_er", gmii_tx_er, 0);
    check("rst_tready", bus.tready, 0);
    check("rst_start", start_packet, 0);
    check("rst_underflow", error_underflow, 0);
    tx_rst = 1'b0;
    @(posedge tx_clk);
    #1;

    // Table-driven single frames.
    vecs[0] = '{len: 1,   bad: 1'b0, base: 8'hAB, exp_en: 72,  exp_er: 0};
    vecs[1] = '{len: 60,  bad: 1'b0, base: 8'h10, exp_en: 72,  exp_er: 0};
    vecs[2] = '{len: 64,  bad: 1'b1, base: 8'h33, exp_en: 76,  exp_er: 4};
    vecs[3] = '{len: 59,  bad: 1'b0, base: 8'hC1, exp_en: 72,  exp_er: 0};
    vecs[4] = '{len: 61,  bad: 1'b0, base: 8'h05, exp_en: 73,  exp_er: 0};
    vecs[5] = '{len: 100, bad: 1'b0, base: 8'h7E, exp_en: 112, exp_er: 0};
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      log_q.delete();
      pay_q.delete();
      for (int i = 0; i < vecs[v].len; i++) pay_q.push_back(8'(vecs[v].base + 8'(i * 7)));
      build_model();
      drive_frame(vecs[v].bad, ok);
      repeat (120) @(posedge tx_clk);
      #1;
      find_runs();
      check({nm, "_runs"}, run_start.size(), 1);
      if (run_start.size() > 0) begin
        check({nm, "_en_cycles"}, run_len[0], vecs[v].exp_en);
        check({nm, "_er_cycles"}, count_er(0), vecs[v].exp_er);
        check_frame(0, vecs[v].bad, nm);
      end
      check({nm, "_underflow"}, count_uf(), 0);
    end

    // Back-to-back frames with a 12-cycle gap: 12 IFG cycles plus one IDLE.
    log_q.delete();
    cfg_ifg = 8'd12;
    pay_q.delete();
    for (int i = 0; i < 5; i++) pay_q.push_back(8'(i + 1));
    drive_frame(1'b0, ok);
    drive_frame(1'b0, ok);
    repeat (120) @(posedge tx_clk);
    #1;
    find_runs();
    check("b2b_runs", run_start.size(), 2);
    if (run_start.size() == 2) check("b2b_gap", run_start[1] - run_start[0] - run_len[0], 13);

    // Randomized back-to-back frames against the model.
    rnd_pay.delete();
    for (int f = 0; f < N_RND; f++) begin
      len_a[f] = $urandom_range(1, 80);
      bad_a[f] = ($urandom_range(0, 3) == 0);
      ifg_a[f] = (f == 1) ? 0 : $urandom_range(0, 15);
      off_a[f] = rnd_pay.size();
      for (int i = 0; i < len_a[f]; i++) rnd_pay.push_back(8'($urandom));
    end
    log_q.delete();
    for (int f = 0; f < N_RND; f++) begin
      cfg_ifg = 8'(ifg_a[f]);
      pay_q.delete();
      for (int i = 0; i < len_a[f]; i++) pay_q.push_back(rnd_pay[off_a[f] + i]);
      drive_frame(bad_a[f], ok);
    end
    repeat (150) @(posedge tx_clk);
    #1;
    find_runs();
    check("rnd_runs", run_start.size(), N_RND);
    if (run_start.size() == N_RND) begin
      for (int f = 0; f < N_RND; f++) begin
        pay_q.delete();
        for (int i = 0; i < len_a[f]; i++) pay_q.push_back(rnd_pay[off_a[f] + i]);
        build_model();
        check_frame(f, bad_a[f], $sformatf("rnd%0d", f));
        if (f > 0) begin
          check($sformatf("rnd%0d_gap", f), run_start[f] - run_start[f-1] - run_len[f-1],
                ((ifg_a[f] == 0) ? 1 : ifg_a[f]) + 1);
        end
      end
    end
    check("rnd_underflow", count_uf(), 0);

    // Underflow after byte 10 of 100; the other 90 are drained, no FCS.
    log_q.delete();
    cfg_ifg = 8'd12;
    pay_q.delete();
    for (int i = 0; i < 100; i++) pay_q.push_back(8'(8'h40 + i));
    build_model();
    drive_range(0, 10, 1'b0, ok);
    @(posedge tx_clk);
    #1;
    drive_range(10, 100, 1'b0, ok);
    check("uf_drain_accepted", ok, 1);
    repeat (60) @(posedge tx_clk);
    #1;
    find_runs();
    check("uf_runs", run_start.size(), 1);
    if (run_start.size() == 1) begin
      int s, wrong;
      s = run_start[0];
      check("uf_en_cycles", run_len[0], 19);
      check("uf_er_cycles", count_er(0), 1);
      check("uf_er_last", log_q[s+18].er, 1);
      check("uf_pulse_pos", log_q[s+18].uf, 1);
      wrong = 0;
      for (int i = 0; i < 18; i++) if (log_q[s+i].d !== exp_q[i]) wrong++;
      check("uf_bytes_wrong", wrong, 0);
    end
    check("uf_pulses", count_uf(), 1);

    // Reset while padding a 1-byte frame truncates it at once.
    pay_q.delete();
    pay_q.push_back(8'hAB);
    drive_frame(1'b0, ok);
    repeat (5) @(posedge tx_clk);
    @(negedge tx_clk);
    check("pad_before_rst_en", gmii_tx_en, 1);
    tx_rst = 1'b1;
    @(posedge tx_clk);
    #1;
    check("pad_rst_en", gmii_tx_en, 0);
    check("pad_rst_txd", gmii_txd, 8'h00);
    check("pad_rst_tready", bus.tready, 0);
    @(negedge tx_clk);
    tx_rst = 1'b0;
    log_q.delete();
    repeat (80) @(posedge tx_clk);
    #1;
    find_runs();
    check("post_rst_runs", run_start.size(), 0);

    // Start gating: held off while disabled; mid-frame disable is ignored.
    log_q.delete();
    cfg_tx_enable = 1'b0;
    bus.tvalid    = 1'b1;
    bus.tdata     = 8'h11;
    bus.tlast     = 1'b0;
    repeat (30) @(posedge tx_clk);
    #1;
    find_runs();
    check("gated_runs", run_start.size(), 0);
    check("gated_tready", bus.tready, 0);
    log_q.delete();
    cfg_tx_enable = 1'b1;
    pay_q.delete();
    for (int i = 0; i < 3; i++) pay_q.push_back(8'(8'h11 + i));
    build_model();
    fork
      drive_frame(1'b0, ok);
      begin
        repeat (12) @(posedge tx_clk);
        #1;
        cfg_tx_enable = 1'b0;
      end
    join
    repeat (100) @(posedge tx_clk);
    #1;
    find_runs();
    check("ungated_runs", run_start.size(), 1);
    if (run_start.size() == 1) check_frame(0, 1'b0, "ungated");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
